// File: rtl/pcileech_pcie_bar_cpl_a7.sv
// BAR0 completer: accepts 1DW MRd32/MWr32 TLPs on the 64-bit RX stream, writes or reads a
// small DW register file, and answers reads with a two-beat CplD on the TX stream.
module pcileech_pcie_bar_cpl_a7 #(
  parameter int          REG_COUNT = 16,
  parameter logic [31:0] ID_VALUE  = 32'h1234ABCD
) (
  input  logic        clk_pcie,
  input  logic        rst,
  input  logic [63:0] rx_data,
  input  logic [7:0]  rx_keep,
  input  logic        rx_last,
  input  logic        rx_valid,
  input  logic        rx_bar0_hit,
  output logic        rx_ready,
  output logic [63:0] tx_data,
  output logic [7:0]  tx_keep,
  output logic        tx_last,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] cfg_completer_id,
  output logic [15:0] cpl_count,
  output logic [15:0] drop_count
);

  localparam int IDXW = $clog2(REG_COUNT);

  typedef enum logic [2:0] {S_RX_H, S_RX_D, S_DROP, S_TX0, S_TX1} state_t;

  state_t      r_state;
  logic        r_rx_ready;
  logic        r_is_wr;
  logic [31:0] r_dw1;
  logic [31:0] r_rd_data;
  logic [6:0]  r_lower_addr;
  logic [63:0] r_tx_data;
  logic [7:0]  r_tx_keep;
  logic        r_tx_last;
  logic        r_tx_valid;
  logic [15:0] r_cpl_count;
  logic [15:0] r_drop_count;

  logic            w_rx_fire;
  logic            w_hdr_ok;
  logic            w_wr_en;
  logic [IDXW-1:0] w_idx;
  logic [3:0]      w_be;
  logic [11:0]     w_byte_count;
  logic [1:0]      w_lo_bits;
  logic [31:0]     w_regs [REG_COUNT];
  logic            w_unused;

  assign w_rx_fire = rx_valid & r_rx_ready;
  assign w_idx     = rx_data[IDXW+1:2];
  assign w_be      = r_dw1[3:0];
  assign w_hdr_ok  = ((rx_data[31:24] == 8'h00) || (rx_data[31:24] == 8'h40)) &&
                     (rx_data[9:0] == 10'd1) && rx_bar0_hit && !rx_last;
  assign w_wr_en   = (r_state == S_RX_D) && w_rx_fire && rx_last && r_is_wr;
  assign w_unused  = &{1'b0, rx_keep, r_dw1[7:4], rx_data[23:10]};

  always_comb begin
    w_byte_count = 12'd1;
    casez (w_be)
      4'b1??1:                   w_byte_count = 12'd4;
      4'b01?1, 4'b1?10:          w_byte_count = 12'd3;
      4'b0011, 4'b0110, 4'b1100: w_byte_count = 12'd2;
      default:                   w_byte_count = 12'd1;
    endcase
  end

  always_comb begin
    w_lo_bits = 2'd0;
    casez (w_be)
      4'b???1: w_lo_bits = 2'd0;
      4'b??10: w_lo_bits = 2'd1;
      4'b?100: w_lo_bits = 2'd2;
      4'b1000: w_lo_bits = 2'd3;
      default: w_lo_bits = 2'd0;
    endcase
  end

  // Reg 0 is a constant ID; the rest are byte-lane writable and cleared on reset.
  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      if (gi == 0) begin : g_id
        assign w_regs[gi] = ID_VALUE;
      end else begin : g_rw
        logic [31:0] r_reg;
        always_ff @(posedge clk_pcie) begin
          if (rst) begin
            r_reg <= 32'h0;
          end else if (w_wr_en && (w_idx == IDXW'(gi))) begin
            for (int b = 0; b < 4; b++) begin
              if (w_be[b]) r_reg[8*b +: 8] <= rx_data[32 + 8*b +: 8];
            end
          end
        end
        assign w_regs[gi] = r_reg;
      end
    end
  endgenerate

  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      r_state      <= S_RX_H;
      r_rx_ready   <= 1'b0;
      r_is_wr      <= 1'b0;
      r_dw1        <= 32'h0;
      r_rd_data    <= 32'h0;
      r_lower_addr <= 7'h0;
      r_tx_data    <= 64'h0;
      r_tx_keep    <= 8'h0;
      r_tx_last    <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_cpl_count  <= 16'h0;
      r_drop_count <= 16'h0;
    end else begin
      case (r_state)
        S_RX_H: begin
          r_rx_ready <= 1'b1;
          if (w_rx_fire) begin
            r_dw1   <= rx_data[63:32];
            r_is_wr <= rx_data[30];
            if (rx_last) begin
              if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            end else if (w_hdr_ok) begin
              r_state <= S_RX_D;
            end else begin
              r_state <= S_DROP;
            end
          end
        end
        S_RX_D: begin
          if (w_rx_fire) begin
            if (!rx_last) begin
              r_state <= S_DROP;
            end else if (r_is_wr) begin
              r_state <= S_RX_H;
            end else begin
              r_rd_data    <= w_regs[w_idx];
              r_lower_addr <= {rx_data[6:2], w_lo_bits};
              r_tx_data    <= {cfg_completer_id, 4'b0000, w_byte_count, 32'h4A000001};
              r_tx_keep    <= 8'hFF;
              r_tx_last    <= 1'b0;
              r_tx_valid   <= 1'b1;
              r_rx_ready   <= 1'b0;
              r_state      <= S_TX0;
            end
          end
        end
        S_DROP: begin
          if (w_rx_fire && rx_last) begin
            if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            r_state <= S_RX_H;
          end
        end
        S_TX0: begin
          if (tx_ready) begin
            r_tx_data <= {r_rd_data, r_dw1[31:16], r_dw1[15:8], 1'b0, r_lower_addr};
            r_tx_last <= 1'b1;
            r_state   <= S_TX1;
          end
        end
        S_TX1: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_tx_keep  <= 8'h0;
            r_tx_data  <= 64'h0;
            r_rx_ready <= 1'b1;
            if (r_cpl_count != 16'hFFFF) r_cpl_count <= r_cpl_count + 16'd1;
            r_state    <= S_RX_H;
          end
        end
        default: r_state <= S_RX_H;
      endcase
    end
  end

  assign rx_ready   = r_rx_ready;
  assign tx_data    = r_tx_data;
  assign tx_keep    = r_tx_keep;
  assign tx_last    = r_tx_last;
  assign tx_valid   = r_tx_valid;
  assign cpl_count  = r_cpl_count;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_pcileech_pcie_bar_cpl_a7.sv
// Bench for the BAR0 completer: table of TLPs with a TX scoreboard, plus stall and
// reset-during-completion sequences.
`timescale 1ns/1ps
module tb_pcileech_pcie_bar_cpl_a7;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rx_data;
  logic [7:0]  rx_keep;
  logic        rx_last;
  logic        rx_valid;
  logic        rx_bar0_hit;
  logic        rx_ready;
  logic [63:0] tx_data;
  logic [7:0]  tx_keep;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] cfg_completer_id;
  logic [15:0] cpl_count;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  pcileech_pcie_bar_cpl_a7 #(.REG_COUNT(16), .ID_VALUE(32'h1234ABCD)) dut (
    .clk_pcie(clk), .rst(rst),
    .rx_data(rx_data), .rx_keep(rx_keep), .rx_last(rx_last), .rx_valid(rx_valid),
    .rx_bar0_hit(rx_bar0_hit), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_keep(tx_keep), .tx_last(tx_last), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .cfg_completer_id(cfg_completer_id),
    .cpl_count(cpl_count), .drop_count(drop_count)
  );

  typedef struct {
    logic [7:0]  fmt;
    logic [9:0]  len;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [7:0]  tag;
    logic [15:0] req;
    logic [31:0] wdata;
    logic        bar;
    int          nbeats;
    bit          exp_cpl;
    logic [31:0] exp_rdata;
    logic [11:0] exp_bc;
    logic [6:0]  exp_la;
    int          exp_drops;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int total = 0;
  int bad = 0;
  int exp_cpls = 0;
  logic [64:0] exp_q [$];
  logic [64:0] mon_exp;

  function automatic vec_t mk(logic [7:0] fmt, logic [9:0] len, logic [31:0] addr, logic [3:0] be,
                              logic [7:0] tag, logic [15:0] req, logic [31:0] wdata, logic bar,
                              int nbeats, bit exp_cpl, logic [31:0] exp_rdata, logic [11:0] exp_bc,
                              logic [6:0] exp_la, int exp_drops);
    vec_t v;
    v.fmt = fmt; v.len = len; v.addr = addr; v.be = be; v.tag = tag; v.req = req;
    v.wdata = wdata; v.bar = bar; v.nbeats = nbeats; v.exp_cpl = exp_cpl;
    v.exp_rdata = exp_rdata; v.exp_bc = exp_bc; v.exp_la = exp_la; v.exp_drops = exp_drops;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every beat the DUT hands over is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected got=%h last=%b", tx_data, tx_last);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({tx_last, tx_data} !== mon_exp || tx_keep !== 8'hFF) begin
          bad++;
          $display("FAIL tx_beat got=%b_%h keep=%h exp=%b_%h keep=ff",
                   tx_last, tx_data, tx_keep, mon_exp[64], mon_exp[63:0]);
        end
      end
    end
  end

  task automatic rx_beat(input logic [63:0] d, input logic last, input logic bar);
    int n;
    rx_data = d; rx_last = last; rx_valid = 1'b1; rx_bar0_hit = bar; n = 0;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      total++; bad++;
      $display("FAIL rx_timeout got=rx_ready0 exp=rx_ready1");
    end
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  task automatic send(input vec_t v);
    logic [63:0] b0, b1;
    b0 = {v.req, v.tag, 4'h0, v.be, v.fmt, 14'd0, v.len};
    b1 = {v.wdata, v.addr};
    if (v.exp_cpl) begin
      exp_q.push_back({1'b0, cfg_completer_id, 4'h0, v.exp_bc, 32'h4A000001});
      exp_q.push_back({1'b1, v.exp_rdata, v.req, v.tag, 1'b0, v.exp_la});
      exp_cpls++;
    end
    if (v.nbeats == 1) begin
      rx_beat(b0, 1'b1, v.bar);
    end else begin
      rx_beat(b0, 1'b0, v.bar);
      rx_beat(b1, v.nbeats == 2, v.bar);
      if (v.nbeats > 2) rx_beat(64'h0000CAFE_0000F00D, 1'b1, v.bar);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL cpl_timeout got=pending%0d exp=pending0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_valid();
    int n;
    n = 0;
    while (!tx_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("tx_valid_rise", {63'd0, tx_valid}, 64'd1);
  endtask

  vec_t v;

  initial begin
    vecs[0]  = mk(8'h00, 10'd1, 32'h00, 4'hF, 8'h05, 16'h0100, 32'h0, 1, 2, 1, 32'h1234ABCD, 12'd4, 7'h00, 0);
    vecs[1]  = mk(8'h40, 10'd1, 32'h08, 4'h3, 8'h00, 16'h0100, 32'hDEADBEEF, 1, 2, 0, 32'h0, 12'd0, 7'h0, 0);
    vecs[2]  = mk(8'h00, 10'd1, 32'h08, 4'hF, 8'h06, 16'h0100, 32'h0, 1, 2, 1, 32'h0000BEEF, 12'd4, 7'h08, 0);
    vecs[3]  = mk(8'h00, 10'd1, 32'h08, 4'h6, 8'h07, 16'h0100, 32'h0, 1, 2, 1, 32'h0000BEEF, 12'd2, 7'h09, 0);
    vecs[4]  = mk(8'h40, 10'd1, 32'h00, 4'hF, 8'h00, 16'h0100, 32'hFFFFFFFF, 1, 2, 0, 32'h0, 12'd0, 7'h0, 0);
    vecs[5]  = mk(8'h00, 10'd1, 32'h00, 4'hF, 8'h08, 16'h0100, 32'h0, 1, 2, 1, 32'h1234ABCD, 12'd4, 7'h00, 0);
    vecs[6]  = mk(8'h00, 10'd1, 32'h40, 4'hF, 8'h09, 16'h0100, 32'h0, 1, 2, 1, 32'h1234ABCD, 12'd4, 7'h40, 0);
    vecs[7]  = mk(8'h40, 10'd1, 32'h3C, 4'hC, 8'h00, 16'h0100, 32'hA5A51234, 1, 2, 0, 32'h0, 12'd0, 7'h0, 0);
    vecs[8]  = mk(8'h00, 10'd1, 32'h7C, 4'h1, 8'h0A, 16'h0100, 32'h0, 1, 2, 1, 32'hA5A50000, 12'd1, 7'h7C, 0);
    vecs[9]  = mk(8'h00, 10'd1, 32'h3C, 4'h9, 8'h0B, 16'hBEEF, 32'h0, 1, 2, 1, 32'hA5A50000, 12'd4, 7'h3C, 0);
    vecs[10] = mk(8'h00, 10'd1, 32'h14, 4'h0, 8'h0C, 16'h0100, 32'h0, 1, 2, 1, 32'h00000000, 12'd1, 7'h14, 0);
    vecs[11] = mk(8'h00, 10'd1, 32'h3C, 4'h5, 8'h0D, 16'h0100, 32'h0, 1, 2, 1, 32'hA5A50000, 12'd3, 7'h3C, 0);
    vecs[12] = mk(8'h00, 10'd1, 32'h3C, 4'hA, 8'h0E, 16'h0100, 32'h0, 1, 2, 1, 32'hA5A50000, 12'd3, 7'h3D, 0);
    vecs[13] = mk(8'h40, 10'd1, 32'h3C, 4'h2, 8'h00, 16'h0100, 32'h00007700, 1, 2, 0, 32'h0, 12'd0, 7'h0, 0);
    vecs[14] = mk(8'h00, 10'd1, 32'h3C, 4'hF, 8'h0F, 16'h0100, 32'h0, 1, 2, 1, 32'hA5A57700, 12'd4, 7'h3C, 0);
    vecs[15] = mk(8'h00, 10'd2, 32'h08, 4'hF, 8'h10, 16'h0100, 32'h0, 1, 2, 0, 32'h0, 12'd0, 7'h0, 1);
    vecs[16] = mk(8'h20, 10'd1, 32'h08, 4'hF, 8'h11, 16'h0100, 32'h0, 1, 2, 0, 32'h0, 12'd0, 7'h0, 2);
    vecs[17] = mk(8'h40, 10'd1, 32'h08, 4'hF, 8'h12, 16'h0100, 32'h55555555, 0, 2, 0, 32'h0, 12'd0, 7'h0, 3);
    vecs[18] = mk(8'h00, 10'd1, 32'h08, 4'hF, 8'h13, 16'h0100, 32'h0, 1, 1, 0, 32'h0, 12'd0, 7'h0, 4);
    vecs[19] = mk(8'h40, 10'd1, 32'h08, 4'hF, 8'h14, 16'h0100, 32'h11111111, 1, 3, 0, 32'h0, 12'd0, 7'h0, 5);
    vecs[20] = mk(8'h00, 10'd1, 32'h08, 4'hF, 8'h15, 16'h0100, 32'h0, 1, 2, 1, 32'h0000BEEF, 12'd4, 7'h08, 5);

    rst = 1'b1; rx_data = 64'h0; rx_keep = 8'hFF; rx_last = 1'b0; rx_valid = 1'b0;
    rx_bar0_hit = 1'b0; tx_ready = 1'b1; cfg_completer_id = 16'h0300;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
    chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_tx_last", {63'd0, tx_last}, 64'd0);
    chk("rst_tx_keep", {56'd0, tx_keep}, 64'd0);
    chk("rst_tx_data", tx_data, 64'd0);
    chk("rst_cpl_count", {48'd0, cpl_count}, 64'd0);
    chk("rst_drop_count", {48'd0, drop_count}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      send(vecs[i]);
      wait_idle();
      chk("drop_count", {48'd0, drop_count}, 64'(vecs[i].exp_drops));
      chk("cpl_count", {48'd0, cpl_count}, 64'(exp_cpls));
      $display("vec %0d fmt=%h addr=%h be=%h cpl=%0d drop=%0d", i, vecs[i].fmt, vecs[i].addr,
               vecs[i].be, cpl_count, drop_count);
    end

    // Completion held off by tx_ready=0 for ten cycles.
    tx_ready = 1'b0;
    v = mk(8'h00, 10'd1, 32'h3C, 4'hF, 8'h33, 16'h0200, 32'h0, 1, 2, 1, 32'hA5A57700, 12'd4, 7'h3C, 5);
    send(v);
    wait_tx_valid();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_tx_data", tx_data, {16'h0300, 4'h0, 12'd4, 32'h4A000001});
      chk("stall_tx_valid", {63'd0, tx_valid}, 64'd1);
      chk("stall_rx_ready", {63'd0, rx_ready}, 64'd0);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_idle();
    chk("stall_cpl_count", {48'd0, cpl_count}, 64'(exp_cpls));
    $display("stall seq cpl=%0d", cpl_count);

    // Reset while the second completion beat is stalled.
    tx_ready = 1'b0;
    v = mk(8'h00, 10'd1, 32'h3C, 4'hF, 8'h44, 16'h0200, 32'h0, 1, 2, 1, 32'hA5A57700, 12'd4, 7'h3C, 5);
    send(v);
    wait_tx_valid();
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("tx1_stall_last", {63'd0, tx_last}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rstmid_rx_ready", {63'd0, rx_ready}, 64'd0);
    chk("rstmid_tx_last", {63'd0, tx_last}, 64'd0);
    chk("rstmid_cpl_count", {48'd0, cpl_count}, 64'd0);
    chk("rstmid_drop_count", {48'd0, drop_count}, 64'd0);
    exp_q.delete();
    exp_cpls = 0;
    rst = 1'b0;
    tx_ready = 1'b1;
    $display("reset seq done");

    v = mk(8'h00, 10'd1, 32'h3C, 4'hF, 8'h50, 16'h0200, 32'h0, 1, 2, 1, 32'h00000000, 12'd4, 7'h3C, 0);
    send(v);
    wait_idle();
    v = mk(8'h00, 10'd1, 32'h08, 4'hF, 8'h51, 16'h0200, 32'h0, 1, 2, 1, 32'h00000000, 12'd4, 7'h08, 0);
    send(v);
    wait_idle();
    chk("post_rst_cpl_count", {48'd0, cpl_count}, 64'd2);
    chk("post_rst_drop_count", {48'd0, drop_count}, 64'd0);
    $display("post reset reads cpl=%0d drop=%0d", cpl_count, drop_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
